// File: rtl/axi_burst_pkg.sv
// Shared constants, FSM state types and width helper for the AXI burst master.
package axi_burst_pkg;

  // Response codes on RRESP/BRESP; anything other than OKAY is an error.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  // Width of the len field (beats-1); kept at least 1 bit so single-beat
  // configurations still have a legal field.
  function automatic int len_w(input int max_len);
    return (max_len <= 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/axi_burst_wr.sv
// Write burst engine: address phase, beat streaming from a latched buffer,
// then the write response. All outputs are registered.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; VALID, once raised, stays up with its payload
// stable until that edge.
module axi_burst_wr
  import axi_burst_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 8,
  parameter  int ID_W    = 4,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = len_w(MAX_LEN),
  localparam int CMD_W   = ADDR_W + LEN_W + ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_start,
  input  logic [CMD_W-1:0]          wr_cmd,
  input  logic [MAX_LEN*DATA_W-1:0] wr_data,
  output logic                      wr_done,
  output logic                      wr_err,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [CMD_W-1:0]          AWCMD,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [DATA_W-1:0]         WDATA,
  output logic                      WLAST,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP
);

  wr_state_e                 state_q, state_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d, cnt_nx;
  logic [MAX_LEN*DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]          len;
  logic                      aw_valid_d, w_valid_d, w_last_d, b_ready_d;
  logic                      done_d, err_d;
  logic [CMD_W-1:0]          aw_cmd_d;
  logic [DATA_W-1:0]         w_data_d;

  // The latched command is the single source of the burst length.
  assign len    = AWCMD[ID_W +: LEN_W];
  assign cnt_nx = cnt_q + LEN_W'(1);

  // Next state and next register values for every output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    aw_valid_d = AWVALID;
    aw_cmd_d   = AWCMD;
    w_valid_d  = WVALID;
    w_data_d   = WDATA;
    w_last_d   = WLAST;
    b_ready_d  = BREADY;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (wr_start) begin
          state_d    = WR_ADDR;
          aw_valid_d = 1'b1;
          aw_cmd_d   = wr_cmd;
          buf_d      = wr_data;
          cnt_d      = '0;
        end
      end
      WR_ADDR: begin
        if (AWVALID && AWREADY) begin
          state_d    = WR_DATA;
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b1;
          w_data_d   = buf_q[0 +: DATA_W];
          w_last_d   = (len == '0);
        end
      end
      WR_DATA: begin
        if (WVALID && WREADY) begin
          if (WLAST) begin
            state_d   = WR_RESP;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_data_d  = '0;
            b_ready_d = 1'b1;
          end else begin
            cnt_d    = cnt_nx;
            w_data_d = buf_q[cnt_nx*DATA_W +: DATA_W];
            w_last_d = (cnt_nx == len);
          end
        end
      end
      WR_RESP: begin
        if (BVALID && BREADY) begin
          state_d   = WR_IDLE;
          b_ready_d = 1'b0;
          done_d    = 1'b1;
          err_d     = (BRESP != RESP_OKAY);
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      AWVALID <= 1'b0;
      AWCMD   <= '0;
      WVALID  <= 1'b0;
      WDATA   <= '0;
      WLAST   <= 1'b0;
      BREADY  <= 1'b0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      AWVALID <= aw_valid_d;
      AWCMD   <= aw_cmd_d;
      WVALID  <= w_valid_d;
      WDATA   <= w_data_d;
      WLAST   <= w_last_d;
      BREADY  <= b_ready_d;
      wr_done <= done_d;
      wr_err  <= err_d;
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// AXI-style burst master: an independent read engine (here) and write engine
// (axi_burst_wr) sharing only the clock and reset. All outputs are registered.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; VALID, once raised, stays up with its payload
// stable until that edge.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 8,
  parameter  int ID_W    = 4,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = len_w(MAX_LEN),
  localparam int CMD_W   = ADDR_W + LEN_W + ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_start,
  input  logic [CMD_W-1:0]          rd_cmd,
  output logic [MAX_LEN*DATA_W-1:0] rd_data,
  output logic                      rd_done,
  output logic                      rd_err,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [CMD_W-1:0]          ARCMD,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      wr_start,
  input  logic [CMD_W-1:0]          wr_cmd,
  input  logic [MAX_LEN*DATA_W-1:0] wr_data,
  output logic                      wr_done,
  output logic                      wr_err,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [CMD_W-1:0]          AWCMD,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [DATA_W-1:0]         WDATA,
  output logic                      WLAST,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP
);

  rd_state_e                 rd_state_q, rd_state_d;
  // One extra bit so the count can sit at len+1 and flag overrun beats.
  logic [LEN_W:0]            cnt_q, cnt_d;
  logic                      err_acc_q, err_acc_d;
  logic [LEN_W-1:0]          rd_len;
  logic                      beat_err;
  logic                      ar_valid_d, r_ready_d, done_d, err_d;
  logic [CMD_W-1:0]          ar_cmd_d;
  logic [MAX_LEN*DATA_W-1:0] data_d;

  assign rd_len = ARCMD[ID_W +: LEN_W];

  // Read engine next state, beat capture and error accumulation.
  always_comb begin
    rd_state_d = rd_state_q;
    cnt_d      = cnt_q;
    err_acc_d  = err_acc_q;
    ar_valid_d = ARVALID;
    ar_cmd_d   = ARCMD;
    r_ready_d  = RREADY;
    data_d     = rd_data;
    done_d     = 1'b0;
    err_d      = 1'b0;
    beat_err   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_start) begin
          rd_state_d = RD_ADDR;
          ar_valid_d = 1'b1;
          ar_cmd_d   = rd_cmd;
          data_d     = '0;
          cnt_d      = '0;
          err_acc_d  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (ARVALID && ARREADY) begin
          rd_state_d = RD_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (RVALID && RREADY) begin
          beat_err = (RRESP != RESP_OKAY);
          if (cnt_q <= {1'b0, rd_len}) begin
            data_d[cnt_q[LEN_W-1:0]*DATA_W +: DATA_W] = RDATA;
            cnt_d = cnt_q + (LEN_W+1)'(1);
          end else begin
            // Beat past the requested length: dropped, but remembered.
            beat_err = 1'b1;
          end
          if (RLAST) begin
            if (cnt_q != {1'b0, rd_len}) beat_err = 1'b1;
            rd_state_d = RD_IDLE;
            r_ready_d  = 1'b0;
            done_d     = 1'b1;
            err_d      = err_acc_q | beat_err;
          end else begin
            err_acc_d = err_acc_q | beat_err;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read engine state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= RD_IDLE;
      cnt_q      <= '0;
      err_acc_q  <= 1'b0;
      ARVALID    <= 1'b0;
      ARCMD      <= '0;
      RREADY     <= 1'b0;
      rd_data    <= '0;
      rd_done    <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      cnt_q      <= cnt_d;
      err_acc_q  <= err_acc_d;
      ARVALID    <= ar_valid_d;
      ARCMD      <= ar_cmd_d;
      RREADY     <= r_ready_d;
      rd_data    <= data_d;
      rd_done    <= done_d;
      rd_err     <= err_d;
    end
  end

  axi_burst_wr #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ID_W    (ID_W),
    .MAX_LEN (MAX_LEN)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_start),
    .wr_cmd   (wr_cmd),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWCMD    (AWCMD),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WLAST    (WLAST),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP)
  );

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: channel driver tasks, a burst-level
// expectation model feeding queues, one compare process, literal spot checks.
module tb_axi_burst_master;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rd_start, ARREADY, RVALID, RLAST;
  logic [15:0]  rd_cmd;
  logic [127:0] rd_data;
  logic         rd_done, rd_err, ARVALID, RREADY;
  logic [15:0]  ARCMD;
  logic [7:0]   RDATA;
  logic [1:0]   RRESP;
  logic         wr_start, AWREADY, WREADY, BVALID;
  logic [15:0]  wr_cmd;
  logic [127:0] wr_data;
  logic         wr_done, wr_err, AWVALID, WVALID, WLAST, BREADY;
  logic [15:0]  AWCMD;
  logic [7:0]   WDATA;
  logic [1:0]   BRESP;

  int errors = 0;
  int checks = 0;

  // Expectation queues filled by the burst model, drained by the compare process.
  logic [127:0] exp_rd_q[$];
  logic         exp_rderr_q[$];
  logic [8:0]   exp_w_q[$];
  logic         exp_wrerr_q[$];
  logic [15:0]  exp_arcmd, exp_awcmd;
  logic [8:0]   seen_w_q[$];
  logic         last_rd_err, last_wr_err;

  // Read beat stimulus table for the current read burst.
  logic [7:0]   rb [0:19];
  logic [1:0]   rr [0:19];

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .rd_start(rd_start), .rd_cmd(rd_cmd), .rd_data(rd_data), .rd_done(rd_done), .rd_err(rd_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARCMD(ARCMD),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .wr_start(wr_start), .wr_cmd(wr_cmd), .wr_data(wr_data), .wr_done(wr_done), .wr_err(wr_err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWCMD(AWCMD),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, rd_data, '0);
    check({tag, "_rd_flags"}, {rd_done, rd_err, ARVALID, RREADY}, '0);
    check({tag, "_arcmd"}, ARCMD, '0);
    check({tag, "_wr_flags"}, {wr_done, wr_err, AWVALID, WVALID, WLAST, BREADY}, '0);
    check({tag, "_awcmd"}, AWCMD, '0);
    check({tag, "_wdata"}, WDATA, '0);
  endtask

  // Compare process: outputs are stable at the falling edge, and inputs
  // driven just after the rising edge show what the next edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      if (ARVALID) check("arcmd_stable", ARCMD, exp_arcmd);
      if (AWVALID) check("awcmd_stable", AWCMD, exp_awcmd);
      if (rd_done) begin
        last_rd_err = rd_err;
        if (exp_rd_q.size() == 0) check("rd_done_unexpected", 1'b1, 1'b0);
        else begin
          check("rd_data", rd_data, exp_rd_q.pop_front());
          check("rd_err", rd_err, exp_rderr_q.pop_front());
        end
      end
      if (WVALID && WREADY) begin
        seen_w_q.push_back({WLAST, WDATA});
        if (exp_w_q.size() == 0) check("w_beat_unexpected", 1'b1, 1'b0);
        else check("w_beat", {WLAST, WDATA}, exp_w_q.pop_front());
      end
      if (wr_done) begin
        last_wr_err = wr_err;
        if (exp_wrerr_q.size() == 0) check("wr_done_unexpected", 1'b1, 1'b0);
        else check("wr_err", wr_err, exp_wrerr_q.pop_front());
      end
    end
  end

  // Read driver. The model: beats up to index len land in their slot, later
  // ones are dropped; error if any response is non-OKAY, RLAST is not on
  // beat len, or a beat arrives past len.
  task automatic run_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int ar_delay, input int nb, input bit poke);
    logic [127:0] exp_d;
    logic         exp_e;
    int           cnt;
    exp_d = '0;
    exp_e = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (rr[i] != 2'd0) exp_e = 1'b1;
      if (i > int'(len)) exp_e = 1'b1;
      else exp_d[i*8 +: 8] = rb[i];
    end
    if (nb - 1 != int'(len)) exp_e = 1'b1;
    exp_rd_q.push_back(exp_d);
    exp_rderr_q.push_back(exp_e);
    exp_arcmd = {addr, len, id};
    rd_cmd = {addr, len, id};
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_cmd = '0;
    check("arvalid_after_start", ARVALID, 1'b1);
    for (int i = 0; i < ar_delay; i++) begin
      if (poke && i == 0) begin
        rd_start = 1'b1;
        rd_cmd = 16'hFFFF;
      end
      tick();
      rd_start = 1'b0;
      rd_cmd = '0;
    end
    check("arvalid_held", ARVALID, 1'b1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("arvalid_dropped", ARVALID, 1'b0);
    check("rready_in_data", RREADY, 1'b1);
    for (int i = 0; i < nb; i++) begin
      RVALID = 1'b1;
      RDATA = rb[i];
      RRESP = rr[i];
      RLAST = (i == nb - 1);
      tick();
    end
    RVALID = 1'b0;
    RDATA = '0;
    RRESP = '0;
    RLAST = 1'b0;
    cnt = 0;
    while (!rd_done && cnt < 20) begin
      tick();
      cnt++;
    end
    check("rd_done_seen", rd_done, 1'b1);
    tick();
    check("rready_idle", RREADY, 1'b0);
  endtask

  // Write driver. The model: beats 0..len in order, WLAST only on beat len,
  // wr_err set exactly when BRESP is non-OKAY.
  task automatic run_write(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [127:0] wd, input int aw_delay, input bit alt,
                           input logic [1:0] bresp, input bit poke);
    int cyc;
    bit fin;
    for (int i = 0; i <= int'(len); i++) exp_w_q.push_back({i == int'(len), wd[i*8 +: 8]});
    exp_wrerr_q.push_back(bresp != 2'd0);
    exp_awcmd = {addr, len, id};
    wr_cmd = {addr, len, id};
    wr_data = wd;
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    wr_cmd = '0;
    wr_data = '0;
    check("awvalid_after_start", AWVALID, 1'b1);
    for (int i = 0; i < aw_delay; i++) begin
      if (poke && i == 0) begin
        wr_start = 1'b1;
        wr_cmd = 16'hFFFF;
        wr_data = '1;
      end
      tick();
      wr_start = 1'b0;
      wr_cmd = '0;
      wr_data = '0;
    end
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 100) begin
      WREADY = alt ? (cyc % 2 == 1) : 1'b1;
      if (WREADY && WVALID && WLAST) fin = 1'b1;
      tick();
      cyc++;
    end
    WREADY = 1'b0;
    check("wlast_sent", fin, 1'b1);
    check("bready_in_resp", BREADY, 1'b1);
    BRESP = bresp;
    BVALID = 1'b1;
    tick();
    BVALID = 1'b0;
    BRESP = '0;
    check("wr_done_pulse", wr_done, 1'b1);
    tick();
    check("bready_idle", BREADY, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [127:0] wd;
    rd_start = 0; rd_cmd = '0; ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 0;
    wr_start = 0; wr_cmd = '0; wr_data = '0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    last_rd_err = 1'bx;
    last_wr_err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      rb[i] = '0;
      rr[i] = '0;
    end
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Read len=3, ARREADY held off two cycles, ignored rd_start in ADDR.
    rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
    run_read(8'h10, 4'd3, 4'd1, 2, 4, 1'b1);
    check("lit_rd_data_44332211", rd_data[31:0], 32'h44332211);
    check("lit_rd_err_ok", last_rd_err, 1'b0);

    // Write len=2 with WREADY low every other cycle, ignored wr_start in ADDR.
    seen_w_q.delete();
    run_write(8'h20, 4'd2, 4'd3, 128'hCCBBAA, 1, 1'b1, 2'd0, 1'b1);
    check("lit_w_count", seen_w_q.size(), 3);
    if (seen_w_q.size() == 3) begin
      check("lit_w_beat0", seen_w_q[0], 9'h0AA);
      check("lit_w_beat1", seen_w_q[1], 9'h0BB);
      check("lit_w_beat2", seen_w_q[2], 9'h1CC);
    end
    check("lit_wr_err_ok", last_wr_err, 1'b0);

    // Read len=3 with RLAST early on beat 1.
    rb[0] = 8'h01; rb[1] = 8'h02;
    run_read(8'h30, 4'd3, 4'd2, 0, 2, 1'b0);
    check("lit_rd_early_last_data", rd_data[31:0], 32'h00000201);
    check("lit_rd_early_last_err", last_rd_err, 1'b1);

    // Read len=0 with SLVERR; upper slots must have been cleared at start.
    rb[0] = 8'h5A; rr[0] = 2'd2;
    run_read(8'h40, 4'd0, 4'd5, 1, 1, 1'b0);
    rr[0] = 2'd0;
    check("lit_rd_len0_data", rd_data, 128'h5A);
    check("lit_rd_len0_err", last_rd_err, 1'b1);

    // Read len=1 with a third beat past len: dropped and flagged.
    rb[0] = 8'hB1; rb[1] = 8'hB2; rb[2] = 8'hB3;
    run_read(8'h50, 4'd1, 4'd6, 0, 3, 1'b0);
    check("lit_rd_overrun_data", rd_data[31:0], 32'h0000B2B1);
    check("lit_rd_overrun_err", last_rd_err, 1'b1);

    // Single-beat write with SLVERR response.
    seen_w_q.delete();
    run_write(8'h60, 4'd0, 4'd7, 128'hEE, 0, 1'b0, 2'd2, 1'b0);
    check("lit_w_single_beat", (seen_w_q.size() == 1) ? seen_w_q[0] : 9'h000, 9'h1EE);
    check("lit_wr_err_slverr", last_wr_err, 1'b1);

    // Full-length read and write started together.
    wd = '0;
    for (int i = 0; i < 16; i++) begin
      rb[i] = 8'hA0 + 8'(i);
      rr[i] = 2'd0;
      wd[i*8 +: 8] = 8'h50 + 8'(i);
    end
    fork
      run_read(8'h70, 4'd15, 4'd8, 1, 16, 1'b0);
      run_write(8'h80, 4'd15, 4'd9, wd, 2, 1'b1, 2'd0, 1'b0);
    join
    check("lit_conc_rd_first", rd_data[7:0], 8'hA0);
    check("lit_conc_rd_last", rd_data[127:120], 8'hAF);
    check("lit_conc_rd_err", last_rd_err, 1'b0);
    check("lit_conc_wr_err", last_wr_err, 1'b0);

    // Reset during write DATA with beat 2 on the bus.
    wd = 128'h44332211;
    for (int i = 0; i < 4; i++) exp_w_q.push_back({i == 3, wd[i*8 +: 8]});
    exp_awcmd = {8'h90, 4'd3, 4'd1};
    wr_cmd = {8'h90, 4'd3, 4'd1};
    wr_data = wd;
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    WREADY = 1'b1;
    tick();
    tick();
    WREADY = 1'b0;
    check("lit_pre_reset_wdata", {WVALID, WDATA}, 9'h133);
    rst = 1'b0;
    tick();
    check_all_zero("midreset");
    rst = 1'b1;
    exp_w_q.delete();
    tick();

    // Fresh write after the abandoned one.
    run_write(8'hA0, 4'd1, 4'd2, 128'h7766, 0, 1'b0, 2'd0, 1'b0);
    check("lit_post_reset_wr_err", last_wr_err, 1'b0);

    repeat (3) tick();
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("w_queue_drained", exp_w_q.size(), 0);
    check("wr_queue_drained", exp_wrerr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, beat data width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width.
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter MAX_LEN, default 16; beats per burst 1..MAX_LEN; LEN_W = clog2(MAX_LEN); len field = beats-1.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-low reset.
REQ-007 SHALL have port rd_start  input  1  request read burst.
REQ-008 SHALL have port rd_cmd  input  ADDR_W+LEN_W+ID_W  {addr, len, id}.
REQ-009 SHALL have port rd_data  output  MAX_LEN*DATA_W  beat k in slice [k*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_done  output  1  one-cycle read completion pulse.
REQ-011 SHALL have port rd_err  output  1  read error, valid with rd_done.
REQ-012 SHALL have port ARVALID  output  1  read address valid.
REQ-013 SHALL have port ARREADY  input  1  read address ready.
REQ-014 SHALL have port ARCMD  output  ADDR_W+LEN_W+ID_W  latched rd_cmd.
REQ-015 SHALL have port RVALID  input  1  read beat valid.
REQ-016 SHALL have port RREADY  output  1  read beat ready.
REQ-017 SHALL have port RDATA  input  DATA_W  read beat data.
REQ-018 SHALL have port RRESP  input  2  read beat response, 0 = OKAY.
REQ-019 SHALL have port RLAST  input  1  final read beat.
REQ-020 SHALL have port wr_start  input  1  request write burst.
REQ-021 SHALL have port wr_cmd  input  ADDR_W+LEN_W+ID_W  {addr, len, id}.
REQ-022 SHALL have port wr_data  input  MAX_LEN*DATA_W  beats packed as rd_data.
REQ-023 SHALL have port wr_done  output  1  one-cycle write completion pulse.
REQ-024 SHALL have port wr_err  output  1  write error, valid with wr_done.
REQ-025 SHALL have ports AWVALID out 1, AWREADY in 1, AWCMD out ADDR_W+LEN_W+ID_W (write address channel).
REQ-026 SHALL have ports WVALID out 1, WREADY in 1, WDATA out DATA_W, WLAST out 1 (write data channel).
REQ-027 SHALL have ports BVALID in 1, BREADY out 1, BRESP in 2 (write response, 0 = OKAY).

Function
REQ-028 Read FSM SHALL be IDLE->ADDR on rd_start (latch rd_cmd, clear rd_data, beat_cnt=0); ADDR->DATA on ARVALID&&ARREADY; DATA->IDLE on accepted beat with RLAST.
REQ-029 ARVALID SHALL assert the cycle after rd_start, hold with ARCMD stable until ARREADY; RREADY SHALL be 1 exactly in DATA.
REQ-030 Each RVALID&&RREADY beat SHALL store RDATA in slot beat_cnt and increment beat_cnt; beats beyond len SHALL be dropped.
REQ-031 rd_err SHALL be set if any beat RRESP!=0, RLAST arrives at beat_cnt!=len, or a beat arrives with beat_cnt>len; rd_done/rd_err SHALL pulse the cycle after the RLAST beat.
REQ-032 Write FSM SHALL be IDLE->ADDR on wr_start (latch wr_cmd, wr_data); ADDR->DATA on AWVALID&&AWREADY; DATA->RESP on accepted WLAST beat; RESP->IDLE on BVALID.
REQ-033 In DATA, WVALID=1, WDATA=slot beat_cnt, WLAST=(beat_cnt==len); beat_cnt advances only on WREADY; len=0 sends one beat with WLAST=1.
REQ-034 BREADY SHALL be 1 exactly in RESP; wr_err=(BRESP!=0), pulsed with wr_done the cycle after BVALID.
REQ-035 rd_start/wr_start outside IDLE SHALL be ignored; read and write engines SHALL run concurrently and independently.
REQ-036 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-037 rst==0 at a clk edge SHALL force both FSMs to IDLE and every output (incl. rd_data, ARCMD, AWCMD, WDATA) to 0, abandoning any in-flight burst without completing its handshake.

Structure
REQ-038 Package axi_burst_pkg SHALL hold RESP_OKAY/SLVERR/DECERR constants, read/write FSM state enums and the LEN_W function; write engine SHALL be sub-module axi_burst_wr, instantiated once.

Verification
REQ-039 Read len=3, ARREADY delayed 2 cycles, 4 beats 0x11..0x44 RRESP=0 -> rd_data[31:0]=0x44332211, rd_done=1, rd_err=0.
REQ-040 Write len=2, wr_data=0xCCBBAA, WREADY low every other cycle -> WDATA AA,BB,CC, WLAST on CC only, BRESP=0 -> wr_done=1, wr_err=0.
REQ-041 Read len=3 with RLAST on beat 1 -> return to IDLE, rd_err=1; read len=0 with RRESP=2 -> rd_err=1.
REQ-042 Concurrent read len=15 and write len=15 started same cycle -> both complete, correct data, no cross-interference.
REQ-043 rst=0 during write DATA beat 2 -> next cycle all outputs 0; new wr_start after reset completes normally.
